reg_bank_arbiter: RTL and testbench

- Two-port arbiter and sequencer for a bank of NrOfRegs flip-flop registers that share one write-data bus and one tri-state read bus.
- Accepts read, write, clear and preset requests from two requesters (A = inference control FSM, B = pixel loader) using round-robin priority.
- Generates one-hot per-register ClockEnable, cs, Reset and pre strobes, and returns read data with an acknowledge.

---
 rtl/reg_bank_pkg.sv | 17 +
 rtl/reg_bank_arbiter_rr_arb2.sv | 36 +++
 rtl/reg_bank_arbiter.sv | 144 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants for the register-bank arbiter: operation codes, FSM
// state encodings and requester identities.
package reg_bank_pkg;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_PRESET = 2'd3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant plus a priority pointer
// that moves to the other side only when that side was left waiting.
module rr_arb2
  import reg_bank_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  input  logic owner,
  output logic grant_valid,
  output logic grant_b
);

  logic ptr;

  always_comb begin
    grant_valid = req_a | req_b;
    grant_b     = req_b & (~req_a | (ptr == OWNER_B));
  end

  // Pointer only moves when the finishing owner's competitor is still waiting.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr <= OWNER_A;
    end else if (update) begin
      if (owner == OWNER_A && req_b) begin
        ptr <= OWNER_B;
      end else if (owner == OWNER_B && req_a) begin
        ptr <= OWNER_A;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Arbitrates two requesters onto a bank of flop registers sharing one write
// bus and one tri-state read bus; every bank strobe is driven from a flop.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 4,
  parameter int AddrBits = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                a_req,
  input  logic [1:0]          a_op,
  input  logic [AddrBits-1:0] a_addr,
  input  logic [NrOfBits-1:0] a_wdata,
  output logic                a_ack,
  output logic                a_err,
  output logic [NrOfBits-1:0] a_rdata,
  input  logic                b_req,
  input  logic [1:0]          b_op,
  input  logic [AddrBits-1:0] b_addr,
  input  logic [NrOfBits-1:0] b_wdata,
  output logic                b_ack,
  output logic                b_err,
  output logic [NrOfBits-1:0] b_rdata,
  output logic [NrOfBits-1:0] bank_d,
  output logic [NrOfRegs-1:0] bank_ce,
  output logic [NrOfRegs-1:0] bank_cs,
  output logic [NrOfRegs-1:0] bank_clr,
  output logic [NrOfRegs-1:0] bank_pre,
  input  logic [NrOfBits-1:0] bank_q
);

  logic [1:0]          state;
  logic [1:0]          op_q;
  logic                owner_q;
  logic                addr_err_q;
  logic [NrOfBits-1:0] q_cap;

  logic                grant_valid;
  logic                grant_b;
  logic [1:0]          sel_op;
  logic [AddrBits-1:0] sel_addr;
  logic [NrOfBits-1:0] sel_wdata;
  logic                sel_in_range;
  logic [NrOfRegs-1:0] sel_onehot;

  rr_arb2 u_arb (
    .Clock       (Clock),
    .Reset       (Reset),
    .req_a       (a_req),
    .req_b       (b_req),
    .update      (state == DONE),
    .owner       (owner_q),
    .grant_valid (grant_valid),
    .grant_b     (grant_b)
  );

  // Out-of-range addresses decode to an all-zero select, so no strobe fires.
  always_comb begin
    sel_op       = grant_b ? b_op    : a_op;
    sel_addr     = grant_b ? b_addr  : a_addr;
    sel_wdata    = grant_b ? b_wdata : a_wdata;
    sel_in_range = ({1'b0, sel_addr} < (AddrBits+1)'(NrOfRegs));
    sel_onehot   = '0;
    for (int i = 0; i < NrOfRegs; i++) begin
      sel_onehot[i] = sel_in_range && (sel_addr == AddrBits'(i));
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      op_q       <= OP_READ;
      owner_q    <= OWNER_A;
      addr_err_q <= 1'b0;
      q_cap      <= '0;
      bank_d     <= '0;
      bank_ce    <= '0;
      bank_cs    <= '1;
      bank_clr   <= '0;
      bank_pre   <= '0;
      a_ack      <= 1'b0;
      a_err      <= 1'b0;
      a_rdata    <= '0;
      b_ack      <= 1'b0;
      b_err      <= 1'b0;
      b_rdata    <= '0;
    end else begin
      a_ack <= 1'b0;
      a_err <= 1'b0;
      b_ack <= 1'b0;
      b_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            op_q       <= sel_op;
            owner_q    <= grant_b ? OWNER_B : OWNER_A;
            addr_err_q <= ~sel_in_range;
            state      <= ACCESS;
            case (sel_op)
              OP_READ:  bank_cs <= ~sel_onehot;
              OP_WRITE: begin
                bank_ce <= sel_onehot;
                if (sel_in_range) begin
                  bank_d <= sel_wdata;
                end
              end
              OP_CLEAR:  bank_clr <= sel_onehot;
              default:   bank_pre <= sel_onehot;
            endcase
          end
        end
        // The selected register drives bank_q only while cs is low, so sample now.
        ACCESS: begin
          q_cap    <= bank_q;
          bank_ce  <= '0;
          bank_cs  <= '1;
          bank_clr <= '0;
          bank_pre <= '0;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
          if (owner_q == OWNER_A) begin
            a_ack <= 1'b1;
            a_err <= addr_err_q;
            if (op_q == OP_READ && !addr_err_q) begin
              a_rdata <= q_cap;
            end
          end else begin
            b_ack <= 1'b1;
            b_err <= addr_err_q;
            if (op_q == OP_READ && !addr_err_q) begin
              b_rdata <= q_cap;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench: a 4-register and a 3-register instance, each with a
// simple bank model, checked against a scoreboard of register contents.
module tb_reg_bank_arbiter;

  localparam logic [1:0] T_READ   = 2'd0;
  localparam logic [1:0] T_WRITE  = 2'd1;
  localparam logic [1:0] T_CLEAR  = 2'd2;
  localparam logic [1:0] T_PRESET = 2'd3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  logic       a_req = 1'b0, b_req = 1'b0;
  logic [1:0] a_op = 2'd0, b_op = 2'd0, a_addr = 2'd0, b_addr = 2'd0;
  logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] a_rdata, b_rdata, bank_d, bank_q;
  logic [3:0] bank_ce, bank_cs, bank_clr, bank_pre;

  logic       s_req = 1'b0;
  logic [1:0] s_op = 2'd0, s_addr = 2'd0;
  logic [7:0] s_wdata = 8'h00;
  logic       s_ack, s_err, s_b_ack, s_b_err;
  logic [7:0] s_rdata, s_b_rdata, s_bank_d, s_bank_q;
  logic [2:0] s_bank_ce, s_bank_cs, s_bank_clr, s_bank_pre;

  int checks = 0;
  int passed = 0;
  logic [7:0] sb [4];
  logic [7:0] sb3 [3];

  reg_bank_arbiter #(.NrOfBits(8), .NrOfRegs(4), .AddrBits(2)) dut (
    .Clock(Clock), .Reset(Reset),
    .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .bank_d(bank_d), .bank_ce(bank_ce), .bank_cs(bank_cs),
    .bank_clr(bank_clr), .bank_pre(bank_pre), .bank_q(bank_q)
  );

  reg_bank_arbiter #(.NrOfBits(8), .NrOfRegs(3), .AddrBits(2)) dut3 (
    .Clock(Clock), .Reset(Reset),
    .a_req(s_req), .a_op(s_op), .a_addr(s_addr), .a_wdata(s_wdata),
    .a_ack(s_ack), .a_err(s_err), .a_rdata(s_rdata),
    .b_req(1'b0), .b_op(2'd0), .b_addr(2'd0), .b_wdata(8'h00),
    .b_ack(s_b_ack), .b_err(s_b_err), .b_rdata(s_b_rdata),
    .bank_d(s_bank_d), .bank_ce(s_bank_ce), .bank_cs(s_bank_cs),
    .bank_clr(s_bank_clr), .bank_pre(s_bank_pre), .bank_q(s_bank_q)
  );

  // Bank models: registers with clear/preset/enable, read bus driven by the selected one.
  logic [7:0] mem4 [4] = '{default: 8'h00};
  logic [7:0] mem3 [3] = '{default: 8'h00};

  always @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (bank_clr[i]) mem4[i] <= 8'h00;
      else if (bank_pre[i]) mem4[i] <= 8'hFF;
      else if (bank_ce[i]) mem4[i] <= bank_d;
    end
    for (int i = 0; i < 3; i++) begin
      if (s_bank_clr[i]) mem3[i] <= 8'h00;
      else if (s_bank_pre[i]) mem3[i] <= 8'hFF;
      else if (s_bank_ce[i]) mem3[i] <= s_bank_d;
    end
  end

  always_comb begin
    bank_q = 8'h00;
    for (int i = 0; i < 4; i++) if (!bank_cs[i]) bank_q = mem4[i];
    s_bank_q = 8'h00;
    for (int i = 0; i < 3; i++) if (!s_bank_cs[i]) s_bank_q = mem3[i];
  end

  // Drives one transaction and reports what was seen; callers do the checking.
  task automatic run_op(input bit on3, input bit side_b, input logic [1:0] op,
                        input logic [1:0] addr, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output logic er,
                        output logic [3:0] ce, output logic [3:0] cs,
                        output logic [3:0] clr, output logic [3:0] pre,
                        output logic [7:0] d);
    bit got;
    lat = -1; rd = 8'h00; er = 1'b0; ce = 4'h0; cs = 4'h0; clr = 4'h0; pre = 4'h0; d = 8'h00;
    got = 1'b0;
    if (on3) begin
      s_req = 1'b1; s_op = op; s_addr = addr; s_wdata = wd;
    end else if (side_b) begin
      b_req = 1'b1; b_op = op; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_op = op; a_addr = addr; a_wdata = wd;
    end
    for (int n = 1; n <= 8 && !got; n++) begin
      @(posedge Clock);
      #1;
      if (n == 1) begin
        if (on3) begin
          ce = {1'b0, s_bank_ce}; cs = {1'b1, s_bank_cs};
          clr = {1'b0, s_bank_clr}; pre = {1'b0, s_bank_pre}; d = s_bank_d;
        end else begin
          ce = bank_ce; cs = bank_cs; clr = bank_clr; pre = bank_pre; d = bank_d;
        end
      end
      if (on3 ? s_ack : (side_b ? b_ack : a_ack)) begin
        lat = n;
        got = 1'b1;
        rd = on3 ? s_rdata : (side_b ? b_rdata : a_rdata);
        er = on3 ? s_err : (side_b ? b_err : a_err);
      end
    end
    if (on3) s_req = 1'b0;
    else if (side_b) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) sb[i] = 8'h00;
    for (int i = 0; i < 3; i++) sb3[i] = 8'h00;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if ({bank_ce, bank_cs, bank_clr, bank_pre} !== 16'h0F00)
      $display("[TB] FAIL reset_bank_vectors: got %h expected 0f00", {bank_ce, bank_cs, bank_clr, bank_pre});
    else passed++;
    checks++;
    if ({bank_d, a_rdata, b_rdata, a_ack, a_err, b_ack, b_err} !== 28'h0)
      $display("[TB] FAIL reset_data_ack: got %h expected 0", {bank_d, a_rdata, b_rdata, a_ack, a_err, b_ack, b_err});
    else passed++;
    checks++;
    if ({s_bank_cs, s_bank_ce, s_rdata, s_b_rdata, s_ack, s_b_ack, s_b_err} !== {3'b111, 22'h0})
      $display("[TB] FAIL reset_dut3: got %h expected %h", {s_bank_cs, s_bank_ce, s_rdata, s_b_rdata, s_ack, s_b_ack, s_b_err}, {3'b111, 22'h0});
    else passed++;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_write();
    int lat; logic [7:0] rd, d; logic er; logic [3:0] ce, cs, clr, pre;
    run_op(0, 0, T_WRITE, 2'd2, 8'hA5, lat, rd, er, ce, cs, clr, pre, d);
    sb[2] = 8'hA5;
    checks++;
    if (lat !== 3) $display("[TB] FAIL write_latency: got %0d expected 3", lat); else passed++;
    checks++;
    if ({ce, cs, clr, pre} !== 16'h4F00) $display("[TB] FAIL write_strobes: got %h expected 4f00", {ce, cs, clr, pre}); else passed++;
    checks++;
    if (d !== 8'hA5) $display("[TB] FAIL write_bank_d: got %h expected a5", d); else passed++;
    checks++;
    if (er !== 1'b0) $display("[TB] FAIL write_err: got %b expected 0", er); else passed++;
  endtask

  task automatic test_read();
    int lat; logic [7:0] rd, d; logic er; logic [3:0] ce, cs, clr, pre;
    run_op(0, 0, T_READ, 2'd2, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    checks++;
    if (cs !== 4'b1011) $display("[TB] FAIL read_cs: got %b expected 1011", cs); else passed++;
    checks++;
    if (lat !== 3 || rd !== sb[2]) $display("[TB] FAIL read_data: got lat %0d data %h expected lat 3 data %h", lat, rd, sb[2]); else passed++;
    checks++;
    if (bank_cs !== 4'b1111) $display("[TB] FAIL read_cs_restored: got %b expected 1111", bank_cs); else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_acks;
    a_op = T_WRITE; a_addr = 2'd0; a_wdata = 8'h11;
    b_op = T_WRITE; b_addr = 2'd1; b_wdata = 8'h22;
    a_req = 1'b1; b_req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge Clock);
      #1;
      exp_acks = {(n == 3 || n == 9), (n == 6 || n == 12)};
      checks++;
      if ({a_ack, b_ack} !== exp_acks)
        $display("[TB] FAIL rr_acks_cycle%0d: got %b expected %b", n, {a_ack, b_ack}, exp_acks);
      else passed++;
    end
    a_req = 1'b0; b_req = 1'b0;
    sb[0] = 8'h11; sb[1] = 8'h22;
  endtask

  task automatic test_preset_clear();
    int lat; logic [7:0] rd, d; logic er; logic [3:0] ce, cs, clr, pre;
    run_op(0, 1, T_PRESET, 2'd0, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    checks++;
    if (lat !== 3 || {ce, cs, clr, pre} !== 16'h0F01)
      $display("[TB] FAIL preset_strobe: got lat %0d vec %h expected lat 3 vec 0f01", lat, {ce, cs, clr, pre});
    else passed++;
    run_op(0, 1, T_READ, 2'd0, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    checks++;
    if (rd !== 8'hFF) $display("[TB] FAIL preset_readback: got %h expected ff", rd); else passed++;
    run_op(0, 1, T_CLEAR, 2'd0, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    checks++;
    if (lat !== 3 || {ce, cs, clr, pre} !== 16'h0F10)
      $display("[TB] FAIL clear_strobe: got lat %0d vec %h expected lat 3 vec 0f10", lat, {ce, cs, clr, pre});
    else passed++;
    run_op(0, 1, T_READ, 2'd0, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    sb[0] = 8'h00;
    checks++;
    if (rd !== 8'h00 || er !== 1'b0) $display("[TB] FAIL clear_readback: got %h err %b expected 00 err 0", rd, er); else passed++;
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] rd, d; logic er; logic [3:0] ce, cs, clr, pre;
    run_op(1, 0, T_WRITE, 2'd1, 8'h3C, lat, rd, er, ce, cs, clr, pre, d);
    sb3[1] = 8'h3C;
    run_op(1, 0, T_READ, 2'd1, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    checks++;
    if (rd !== sb3[1] || er !== 1'b0) $display("[TB] FAIL oor_setup_read: got %h err %b expected %h err 0", rd, er, sb3[1]); else passed++;
    run_op(1, 0, T_READ, 2'd3, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    checks++;
    if ({ce, cs, clr, pre} !== 16'h0F00) $display("[TB] FAIL oor_no_strobe: got %h expected 0f00", {ce, cs, clr, pre}); else passed++;
    checks++;
    if (lat !== 3 || er !== 1'b1) $display("[TB] FAIL oor_ack_err: got lat %0d err %b expected lat 3 err 1", lat, er); else passed++;
    checks++;
    if (rd !== 8'h3C) $display("[TB] FAIL oor_rdata_held: got %h expected 3c", rd); else passed++;
    run_op(1, 0, T_PRESET, 2'd3, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    checks++;
    if ({ce, cs, clr, pre} !== 16'h0F00 || er !== 1'b1)
      $display("[TB] FAIL oor_preset: got vec %h err %b expected 0f00 err 1", {ce, cs, clr, pre}, er);
    else passed++;
  endtask

  task automatic test_reset_during_access();
    int lat; int acks_seen; logic [7:0] rd, d; logic er; logic [3:0] ce, cs, clr, pre;
    a_op = T_WRITE; a_addr = 2'd1; a_wdata = 8'h77;
    a_req = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (bank_ce !== 4'b0010) $display("[TB] FAIL rst_access_ce: got %b expected 0010", bank_ce); else passed++;
    #2;
    Reset = 1'b0;
    a_req = 1'b0;
    #1;
    checks++;
    if (bank_ce !== 4'b0000 || bank_cs !== 4'b1111)
      $display("[TB] FAIL rst_async_clear: got ce %b cs %b expected ce 0000 cs 1111", bank_ce, bank_cs);
    else passed++;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    acks_seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge Clock);
      #1;
      if (a_ack) acks_seen++;
    end
    checks++;
    if (acks_seen !== 0) $display("[TB] FAIL rst_no_ack: got %0d acks expected 0", acks_seen); else passed++;
    run_op(0, 0, T_READ, 2'd1, 8'h00, lat, rd, er, ce, cs, clr, pre, d);
    checks++;
    if (lat !== 3 || rd !== sb[1]) $display("[TB] FAIL rst_idle_after: got lat %0d data %h expected lat 3 data %h", lat, rd, sb[1]); else passed++;
  endtask

  task automatic test_random();
    int lat; logic [7:0] rd, d, wd; logic er; logic [3:0] ce, cs, clr, pre, one;
    logic [15:0] exp_vec;
    bit side; logic [1:0] op, addr;
    for (int k = 0; k < 20; k++) begin
      side = 1'($urandom_range(0, 1));
      op   = 2'($urandom_range(0, 3));
      addr = 2'($urandom_range(0, 3));
      wd   = 8'($urandom);
      run_op(0, side, op, addr, wd, lat, rd, er, ce, cs, clr, pre, d);
      one = 4'(1 << addr);
      exp_vec = {(op == T_WRITE) ? one : 4'h0, (op == T_READ) ? ~one : 4'hF,
                 (op == T_CLEAR) ? one : 4'h0, (op == T_PRESET) ? one : 4'h0};
      checks++;
      if (lat !== 3 || er !== 1'b0 || {ce, cs, clr, pre} !== exp_vec)
        $display("[TB] FAIL rand%0d_access: got lat %0d err %b vec %h expected lat 3 err 0 vec %h", k, lat, er, {ce, cs, clr, pre}, exp_vec);
      else passed++;
      if (op == T_READ) begin
        checks++;
        if (rd !== sb[addr]) $display("[TB] FAIL rand%0d_rdata: got %h expected %h", k, rd, sb[addr]); else passed++;
      end else if (op == T_WRITE) begin
        checks++;
        if (d !== wd) $display("[TB] FAIL rand%0d_bank_d: got %h expected %h", k, d, wd); else passed++;
        sb[addr] = wd;
      end else if (op == T_CLEAR) begin
        sb[addr] = 8'h00;
      end else begin
        sb[addr] = 8'hFF;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_preset_clear();
    test_out_of_range();
    test_reset_during_access();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
